// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Single-port, word-addressed memory that answers the core's memory bus. It
// serves one request at a time. A request is accepted in IDLE. The response
// pulse mem_resp comes LATENCY cycles later. The next request is accepted in
// the cycle right after the response.
//
// Writes are byte-enabled and go into the array at the response edge.
// Protocol violations still complete at the normal time. They raise mem_error
// together with mem_resp, and they are ORed into the sticky errcode register.
//
// Optional build macro: MEM_RESPONDER_RANDOM_LAT_EN
//   When defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11) adds 0..7 extra
//   wait cycles to each request. When undefined, no LFSR logic exists and the
//   latency is exactly LATENCY.
//
// Ports
//   clk              in   1   clock
//   rst              in   1   synchronous active-high reset
//   mem_read         in   1   read request, held until mem_resp
//   mem_write        in   1   write request, held until mem_resp
//   mem_address      in  32   byte address
//   mem_wdata        in  32   write data
//   mem_byte_enable  in   4   write lanes, bit i enables byte i
//   mem_resp         out  1   one-cycle completion pulse
//   mem_rdata        out 32   read data, valid with mem_resp, held until next
//   mem_error        out  1   protocol-violation pulse, coincident with mem_resp
//   errcode          out 16   sticky OR of all error bits since reset
//
// Error bits
//   0 read and write together     1 misaligned address
//   2 address outside the window  3 request not held stable while waiting
//   4 write with no byte lanes    15:5 reserved, read as 0
// -----------------------------------------------------------------------------
module mem_responder #(
   parameter int          DEPTH_WORDS = 256,
   parameter int          LATENCY     = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] mem_address,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_byte_enable,
   output logic        mem_resp,
   output logic [31:0] mem_rdata,
   output logic        mem_error,
   output logic [15:0] errcode
);

   localparam int AW    = $clog2(DEPTH_WORDS);
   // Wide enough for LATENCY-1 plus the largest random extension.
   localparam int CNT_W = $clog2(LATENCY + 8) + 1;

   // Illegal configurations are rejected at elaboration rather than
   // silently producing a wrong address map or a stuck LFSR.
   if (LATENCY < 1 || DEPTH_WORDS < 4 ||
       (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0 ||
       BASE_ADDR[1:0] != 2'b00 || LFSR_SEED == 16'h0000) begin : g_param_check
      $error("mem_responder: illegal parameter combination");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   // Latched request
   logic                r_rd;
   logic                r_wr;
   logic [31:0]         r_addr;
   logic [31:0]         r_wdata;
   logic [3:0]          r_be;
   logic [AW-1:0]       r_word;
   logic [4:0]          r_err;
   logic [CNT_W-1:0]    r_cnt;

   // Output registers
   logic [31:0]         r_rdata;
   logic [15:0]         r_errcode;

   // Storage. This array is deliberately not reset.
   logic [31:0]         r_mem [DEPTH_WORDS];

   // Combinational helpers
   logic                w_req;
   logic [31:0]         w_off;
   logic [AW-1:0]       w_word;
   logic                w_oob;
   logic [4:0]          w_acc_err;
   logic                w_hold_viol;
   logic [2:0]          w_extra;
   logic [CNT_W-1:0]    w_wait_cycles;
   logic                w_accept;
   logic                w_enter_resp;
   logic [4:0]          w_resp_err;
   logic                w_resp_rd;
   logic [AW-1:0]       w_rd_word;

   assign w_req  = mem_read | mem_write;

   // Unsigned 32-bit offset. An address below BASE_ADDR wraps to a huge
   // offset, so the range check below catches it as well.
   assign w_off  = mem_address - BASE_ADDR;
   assign w_word = w_off[AW+1:2];
   assign w_oob  = (w_off >> (AW + 2)) != 32'd0;

   assign w_acc_err = {
      (mem_write && (mem_byte_enable == 4'h0)),   // bit4
      1'b0,                                       // bit3 is only set while waiting
      w_oob,                                      // bit2
      (w_off[1:0] != 2'b00),                      // bit1 (base is word aligned)
      (mem_read && mem_write)                     // bit0
   };

   // Any change of the held request while a response is pending.
   assign w_hold_viol = (mem_read        != r_rd)    ||
                        (mem_write       != r_wr)    ||
                        (mem_address     != r_addr)  ||
                        (mem_wdata       != r_wdata) ||
                        (mem_byte_enable != r_be);

`ifdef MEM_RESPONDER_RANDOM_LAT_EN
   logic [15:0] r_lfsr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lfsr <= LFSR_SEED;
      end else begin
         r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      end
   end

   assign w_extra = r_lfsr[2:0];
`else
   assign w_extra = 3'd0;
`endif

   // Number of WAIT cycles this request will spend before RESP.
   assign w_wait_cycles = CNT_W'(LATENCY - 1) + CNT_W'(w_extra);

   // The error set and read source used on the edge that enters RESP.
   // From IDLE (zero wait cycles) they come straight from the bus. From WAIT
   // they come from the latched request plus this cycle's hold check.
   assign w_resp_err = (r_state == S_IDLE) ? w_acc_err
                                           : (r_err | {1'b0, w_hold_viol, 3'b000});
   assign w_resp_rd  = (r_state == S_IDLE) ? mem_read : r_rd;
   assign w_rd_word  = (r_state == S_IDLE) ? w_word   : r_word;

   always_comb begin
      w_state_nxt  = r_state;
      w_accept     = 1'b0;
      w_enter_resp = 1'b0;
      mem_resp     = 1'b0;
      mem_error    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req) begin
               w_accept = 1'b1;
               if (w_wait_cycles == '0) begin
                  w_state_nxt  = S_RESP;
                  w_enter_resp = 1'b1;
               end else begin
                  w_state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (r_cnt == '0) begin
               w_state_nxt  = S_RESP;
               w_enter_resp = 1'b1;
            end
         end
         S_RESP: begin
            mem_resp    = 1'b1;
            mem_error   = |r_err;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_err     <= '0;
         r_rdata   <= 32'h0000_0013;
         r_errcode <= '0;
      end else begin
         r_state <= w_state_nxt;

         if (w_accept) begin
            r_rd    <= mem_read;
            r_wr    <= mem_write;
            r_addr  <= mem_address;
            r_wdata <= mem_wdata;
            r_be    <= mem_byte_enable;
            r_word  <= w_word;
            r_err   <= w_acc_err;
            // The counter holds the remaining WAIT cycles minus one.
            r_cnt   <= (w_wait_cycles == '0) ? '0 : (w_wait_cycles - CNT_W'(1));
         end else if (r_state == S_WAIT) begin
            r_err <= w_resp_err;
            if (r_cnt != '0) begin
               r_cnt <= r_cnt - CNT_W'(1);
            end
         end

         // Read data is captured as RESP is entered, so it is valid during
         // the mem_resp cycle. A write in RESP lands on the following edge
         // and cannot disturb it.
         if (w_enter_resp && w_resp_rd) begin
            r_rdata <= (|w_resp_err) ? 32'h0000_0000 : r_mem[w_rd_word];
         end

         if (r_state == S_RESP) begin
            r_errcode <= r_errcode | {11'd0, r_err};
         end
      end
   end

   // Array update at the RESP edge. A reset on that same edge abandons the
   // transaction.
   always_ff @(posedge clk) begin
      if (!rst && (r_state == S_RESP) && r_wr && (r_err == 5'd0)) begin
         for (int b = 0; b < 4; b++) begin
            if (r_be[b]) begin
               r_mem[r_word][8*b +: 8] <= r_wdata[8*b +: 8];
            end
         end
      end
   end

   assign mem_rdata = r_rdata;
   assign errcode   = r_errcode;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Transaction-level bench for mem_responder in its default build.
//
// The bench model holds:
//   - a word array,
//   - the expected response cycle of the pending request,
//   - its error set, computed from the address/op rules,
//   - the expected mem_rdata and errcode.
//
// Every cycle the outputs are compared against that model. A few literal
// expectations pin both the DUT and the model on the directed cases.
// -----------------------------------------------------------------------------
module tb_mem_responder;

   localparam int          DEPTH = 256;
   localparam int          LAT   = 2;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [31:0] mem_address = 32'h0;
   logic [31:0] mem_wdata = 32'h0;
   logic [3:0]  mem_byte_enable = 4'h0;
   logic        mem_resp;
   logic [31:0] mem_rdata;
   logic        mem_error;
   logic [15:0] errcode;

   mem_responder #(
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (LAT),
      .BASE_ADDR   (BASE),
      .LFSR_SEED   (16'hACE1)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_address     (mem_address),
      .mem_wdata       (mem_wdata),
      .mem_byte_enable (mem_byte_enable),
      .mem_resp        (mem_resp),
      .mem_rdata       (mem_rdata),
      .mem_error       (mem_error),
      .errcode         (errcode)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // Model state
   logic [31:0] m_mem [DEPTH];
   logic [31:0] m_rdata = 32'h0000_0013;
   logic [15:0] m_errcode = 16'h0000;
   int          exp_resp_cyc = -1;
   logic        p_rd, p_wr;
   int          p_word;
   logic [31:0] p_wdata;
   logic [3:0]  p_be;
   logic [4:0]  p_err;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [4:0] model_err(input logic rd, input logic wr,
                                            input logic [31:0] addr, input logic [3:0] be);
      logic [31:0] off;
      logic [4:0]  e;
      off  = addr - BASE;
      e    = 5'd0;
      e[0] = rd && wr;
      e[1] = (addr % 4) != 0;
      e[2] = off >= 32'(4 * DEPTH);
      e[4] = wr && (be == 4'h0);
      return e;
   endfunction

   function automatic int word_of(input logic [31:0] addr);
      logic [31:0] off;
      off = (addr - BASE) >> 2;
      return int'(off % DEPTH);
   endfunction

   // Per-cycle comparison, done at the falling edge.
   task automatic compare();
      logic hit;
      if (rst) begin
         m_rdata   = 32'h0000_0013;
         m_errcode = 16'h0000;
      end else begin
         hit = (cyc == exp_resp_cyc);
         if (hit && p_rd) m_rdata = (p_err != 5'd0) ? 32'h0 : m_mem[p_word];
         chk("resp",    32'(mem_resp),  32'(hit));
         chk("error",   32'(mem_error), 32'(hit && (p_err != 5'd0)));
         chk("rdata",   mem_rdata,      m_rdata);
         chk("errcode", 32'(errcode),   32'(m_errcode));
         if (hit) begin
            m_errcode = m_errcode | {11'd0, p_err};
            if (p_wr && (p_err == 5'd0)) begin
               for (int b = 0; b < 4; b++)
                  if (p_be[b]) m_mem[p_word][8*b +: 8] = p_wdata[8*b +: 8];
            end
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      compare();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // kind: 0 = held normally, 1 = dropped one cycle after acceptance,
   //       2 = reset asserted during the wait
   task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input int kind, input int gap);
      logic [4:0] e;
      repeat (gap) step();
      mem_read        = rd;
      mem_write       = wr;
      mem_address     = addr;
      mem_wdata       = wdata;
      mem_byte_enable = be;
      e = model_err(rd, wr, addr, be);
      if (kind == 1) e[3] = 1'b1;
      if (kind != 2) begin
         p_rd = rd; p_wr = wr; p_word = word_of(addr);
         p_wdata = wdata; p_be = be; p_err = e;
         exp_resp_cyc = cyc + LAT;
      end
      step();
      if (kind == 1) begin
         mem_read = 1'b0; mem_write = 1'b0;
      end
      if (kind == 2) begin
         rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
         step();
         rst = 1'b0;
      end else begin
         repeat (LAT) step();
         mem_read = 1'b0; mem_write = 1'b0;
      end
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      step();
   endtask

   initial begin
      int sel, asel, kind, gap, w;
      logic rd, wr;
      logic [31:0] addr;
      logic [3:0]  be;

      // Reset, then idle
      repeat (3) step();
      rst = 1'b0;
      repeat (5) step();
      chk("rst_resp",    32'(mem_resp),  32'd0);
      chk("rst_error",   32'(mem_error), 32'd0);
      chk("rst_errcode", 32'(errcode),   32'h0000);
      chk("rst_rdata",   mem_rdata,      32'h0000_0013);

      // Fill every word so later reads have known contents
      for (int i = 0; i < DEPTH; i++)
         do_req(1'b0, 1'b1, BASE + 32'(i * 4), $urandom, 4'hF, 0, 0);

      // Full write then read-back
      do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1);
      do_req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 0, 0);
      chk("rd10_full",       mem_rdata, 32'hDEADBEEF);
      chk("model_rd10_full", m_rdata,   32'hDEADBEEF);

      // Partial lanes
      do_req(1'b0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 0, 0);
      do_req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 0, 2);
      chk("rd10_lanes",       mem_rdata, 32'hDE22BE44);
      chk("model_rd10_lanes", m_rdata,   32'hDE22BE44);

      // Read and write together must not modify the array
      do_req(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 0, 0);
      do_req(1'b1, 1'b1, 32'h20, 32'h55555555, 4'hF, 0, 0);
      chk("rdwr_errcode", 32'(errcode), 32'h0001);
      do_req(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 0, 0);
      chk("rd20_unchanged", mem_rdata, 32'hCAFEF00D);

      // Misaligned and out-of-range read
      reset_dut();
      do_req(1'b1, 1'b0, 32'h402, 32'h0, 4'h0, 0, 0);
      chk("oob_rdata",         mem_rdata,      32'h0);
      chk("oob_errcode",       32'(errcode),   32'h0006);
      chk("model_oob_errcode", 32'(m_errcode), 32'h0006);

      // Request dropped during the wait
      reset_dut();
      do_req(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1, 0);
      chk("drop_errcode", 32'(errcode), 32'h0008);
      chk("drop_rdata",   mem_rdata,    32'h0);

      // Reset in the wait of a write
      reset_dut();
      do_req(1'b0, 1'b1, 32'h30, 32'h0BADF00D, 4'hF, 0, 0);
      do_req(1'b0, 1'b1, 32'h30, 32'h12345678, 4'hF, 2, 0);
      chk("abort_errcode", 32'(errcode), 32'h0000);
      chk("abort_rdata",   mem_rdata,    32'h0000_0013);
      do_req(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 0, 0);
      chk("rd30_old", mem_rdata, 32'h0BADF00D);

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         sel  = $urandom_range(0, 9);
         asel = $urandom_range(0, 9);
         kind = $urandom_range(0, 19);
         kind = (kind == 0) ? 2 : ((kind <= 2) ? 1 : 0);
         gap  = $urandom_range(0, 2);
         w    = $urandom_range(0, DEPTH - 1);
         rd   = (sel <= 3) || (sel == 8);
         wr   = (sel >= 4);
         be   = 4'($urandom);
         if (sel == 9) be = 4'h0;
         if (asel == 0)
            addr = BASE + 32'(w * 4) + 32'($urandom_range(1, 3));
         else if (asel == 1)
            addr = ($urandom_range(0, 1) == 0) ? BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 255) * 4)
                                               : BASE - 32'd4;
         else
            addr = BASE + 32'(w * 4);
         do_req(rd, wr, addr, $urandom, be, kind, gap);
      end
      repeat (3) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
